// File: rtl/cle_packer.sv
// Repacks a 32x32 label map from the label SRAM into a 1-bit-per-pixel
// bitmap (128 bytes, MSB = leftmost pixel) and counts foreground pixels.
module cle_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sram_q,
  output logic [9:0]  sram_a,
  output logic [6:0]  pack_a,
  output logic [7:0]  pack_d,
  output logic        pack_wen,
  output logic [10:0] fg_count,
  output logic        finish
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t      state;
  logic [10:0] cnt;
  logic [6:0]  shreg;
  logic        pix;
  logic        smp;
  logic [9:0]  idx;

  // cnt lags the address by one: data for address cnt-1 is on sram_q now
  assign pix = |sram_q;
  assign smp = (cnt != 11'd0) && (cnt <= 11'd1024);
  assign idx = 10'(cnt - 11'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      sram_a   <= '0;
      pack_a   <= '0;
      pack_d   <= '0;
      pack_wen <= 1'b1;
      fg_count <= '0;
      finish   <= 1'b0;
    end else begin
      pack_wen <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= READ;
            cnt      <= '0;
            sram_a   <= '0;
            fg_count <= '0;
            finish   <= 1'b0;
          end
        end
        READ: begin
          cnt <= cnt + 11'd1;
          if (sram_a != 10'h3ff)
            sram_a <= sram_a + 10'd1;
          if (smp) begin
            shreg    <= {shreg[5:0], pix};
            fg_count <= fg_count + {10'd0, pix};
            if (idx[2:0] == 3'd7) begin
              pack_a   <= idx[9:3];
              pack_d   <= {shreg, pix};
              pack_wen <= 1'b0;
            end
          end
          if (cnt == 11'd1025) begin
            state  <= DONE;
            finish <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cle_packer.sv
// Bench for cle_packer: SRAM/bitmap models, constant vectors,
// random maps against a pixel-rule model, restart and reset cases.
module tb_cle_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  sram_q = 8'h00;
  logic [9:0]  sram_a;
  logic [6:0]  pack_a;
  logic [7:0]  pack_d;
  logic        pack_wen;
  logic [10:0] fg_count;
  logic        finish;

  cle_packer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sram_q   (sram_q),
    .sram_a   (sram_a),
    .pack_a   (pack_a),
    .pack_d   (pack_d),
    .pack_wen (pack_wen),
    .fg_count (fg_count),
    .finish   (finish)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  logic [7:0] pk [128];
  int         wr_e [128];
  int         nwr = 0;
  int         ecnt = 0;

  // ecnt before update is the index of the current edge
  always @(posedge clk) begin
    sram_q <= mem[sram_a];
    if (!pack_wen) begin
      pk[pack_a]   <= pack_d;
      wr_e[pack_a] <= ecnt;
      nwr          <= nwr + 1;
    end
    ecnt <= ecnt + 1;
  end

  int passed = 0;
  int total = 0;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  logic [7:0] exp_b [128];
  logic [7:0] rom [128];
  int         exp_fg;
  int         s;

  task automatic ref_model();
    exp_fg = 0;
    for (int b = 0; b < 128; b++) exp_b[b] = 8'h00;
    for (int a = 0; a < 1024; a++)
      if (mem[a] != 8'h00) begin
        exp_b[a / 8][7 - (a % 8)] = 1'b1;
        exp_fg++;
      end
  endtask

  task automatic fill(int kind);
    for (int a = 0; a < 1024; a++) begin
      case (kind)
        1: mem[a] = 8'h01;
        3: mem[a] = (a % 2 == 0) ? 8'h05 : 8'h00;
        4: mem[a] = ($urandom_range(0, 1) == 1) ?
                    8'($urandom_range(1, 255)) : 8'h00;
        5: mem[a] = ($urandom_range(0, 15) == 0) ?
                    8'($urandom_range(1, 255)) : 8'h00;
        default: mem[a] = 8'h00;
      endcase
    end
    if (kind == 2) begin
      mem[0]    = 8'h03;
      mem[1023] = 8'h07;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    s = ecnt;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cyc(int n);
    for (int i = 0; i < 2000 && ecnt - s < n; i++)
      @(negedge clk);
  endtask

  task automatic run_pass(string nm);
    int base;
    int lat;
    int bad_t;
    int bad_d;
    int fg0;
    base = nwr;
    do_start();
    lat = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (finish) begin
        lat = ecnt - s;
        break;
      end
    end
    chk({nm, " latency"}, lat, 1027);
    chk({nm, " writes"}, nwr - base, 128);
    bad_t = 0;
    bad_d = 0;
    for (int j = 0; j < 128; j++) begin
      if (wr_e[j] - s != 8 * j + 10) bad_t++;
      if (pk[j] !== exp_b[j]) begin
        if (bad_d == 0)
          $display("FAIL %s byte %0d: got 0x%0h expected 0x%0h",
                   nm, j, pk[j], exp_b[j]);
        bad_d++;
      end
    end
    chk({nm, " write_timing_errs"}, bad_t, 0);
    chk({nm, " data_errs"}, bad_d, 0);
    chk({nm, " fg_count"}, fg_count, exp_fg);
    chk({nm, " sram_a_hold"}, sram_a, 1023);
    chk({nm, " wen_idle"}, pack_wen, 1);
    fg0 = fg_count;
    repeat (5) @(negedge clk);
    chk({nm, " finish_hold"}, finish, 1);
    chk({nm, " fg_stable"}, fg_count, fg0);
    chk({nm, " no_extra_wr"}, nwr - base, 128);
  endtask

  typedef struct {
    int         kind;
    int         reps;
    int         fg;
    logic [7:0] b0;
    logic [7:0] b127;
    logic [7:0] bmid;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base;
    vecs[0] = '{0, 1, 0,    8'h00, 8'h00, 8'h00};
    vecs[1] = '{1, 1, 1024, 8'hff, 8'hff, 8'hff};
    vecs[2] = '{2, 1, 2,    8'h80, 8'h01, 8'h00};
    vecs[3] = '{3, 2, 512,  8'haa, 8'haa, 8'haa};
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sram_a", sram_a, 0);
    chk("rst pack_a", pack_a, 0);
    chk("rst pack_d", pack_d, 0);
    chk("rst pack_wen", pack_wen, 1);
    chk("rst fg_count", fg_count, 0);
    chk("rst finish", finish, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].kind);
      for (int b = 0; b < 128; b++) exp_b[b] = vecs[v].bmid;
      exp_b[0]   = vecs[v].b0;
      exp_b[127] = vecs[v].b127;
      exp_fg     = vecs[v].fg;
      for (int r = 0; r < vecs[v].reps; r++)
        run_pass($sformatf("vec%0d.%0d", v, r));
    end

    for (int t = 0; t < 3; t++) begin
      fill((t == 1) ? 5 : 4);
      ref_model();
      run_pass($sformatf("rand%0d", t));
    end

    // round trip: arbitrary nonzero labels over a random ROM image
    exp_fg = 0;
    for (int b = 0; b < 128; b++) begin
      rom[b]   = 8'($urandom);
      exp_b[b] = rom[b];
    end
    for (int a = 0; a < 1024; a++) begin
      if (rom[a / 8][7 - (a % 8)]) begin
        mem[a] = 8'((a * 7) % 255 + 1);
        exp_fg++;
      end else begin
        mem[a] = 8'h00;
      end
    end
    run_pass("roundtrip");

    // abort by reset, with an ignored start mid-pass
    fill(3);
    base = nwr;
    do_start();
    wait_cyc(300);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_cyc(400);
    chk("mid sram_a", sram_a, 399);
    wait_cyc(500);
    reset = 1'b1;
    @(negedge clk);
    chk("abort pack_wen", pack_wen, 1);
    chk("abort finish", finish, 0);
    chk("abort fg_count", fg_count, 0);
    chk("abort sram_a", sram_a, 0);
    chk("abort writes", nwr - base, 62);
    base = 0;
    for (int j = 0; j < 62; j++)
      if (wr_e[j] - s != 8 * j + 10) base++;
    chk("abort timing_errs", base, 0);
    base = nwr;
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_abort writes", nwr - base, 0);
    chk("post_abort finish", finish, 0);
    for (int b = 0; b < 128; b++) exp_b[b] = 8'haa;
    exp_fg = 512;
    run_pass("restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
